// File: rtl/piece_queue_sched_if.sv
`default_nettype none
// ============================================================================
// piece_queue_sched_if : bundle between the piece scheduler, the LFSR source,
//                        the game FSM and the preview renderer.
// Revision 1.0
// ============================================================================
interface piece_queue_sched_if #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  logic               new_game;
  logic [2:0]         rand_val;
  logic               piece_req;
  logic               piece_valid;
  logic [2:0]         piece_id;
  logic [3*DEPTH-1:0] preview;
  logic               queue_full;
  logic [6:0]         bag_mask;
  logic [CNT_W-1:0]   pieces_dealt;

  modport master (
    output new_game, rand_val, piece_req,
    input  piece_valid, piece_id, preview, queue_full, bag_mask, pieces_dealt
  );

  modport slave (
    input  new_game, rand_val, piece_req,
    output piece_valid, piece_id, preview, queue_full, bag_mask, pieces_dealt
  );
endinterface
`default_nettype wire

// File: rtl/piece_queue_sched.sv
`default_nettype none
// ============================================================================
// piece_queue_sched : 7-bag next-piece scheduler with a DEPTH-entry preview
//                     queue and a request/valid dealing handshake.
// Revision 1.0
// ============================================================================
module piece_queue_sched #(
  parameter int DEPTH     = 3,
  parameter int MAX_TRIES = 4,
  parameter int CNT_W     = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  piece_queue_sched_if.slave bus
);
  localparam int            CW         = $clog2(DEPTH + 1);
  localparam int            TW         = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] C_LAST_TRY = TW'(MAX_TRIES - 1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       slot_q [DEPTH];
  logic [2:0]       slot_d [DEPTH];
  logic [6:0]       bag_q, bag_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic             valid_q, valid_d;
  logic [2:0]       id_q, id_d;
  logic [CNT_W-1:0] dealt_q, dealt_d;

  logic             pop, accept;
  logic [2:0]       pick, lowest_free;
  logic [6:0]       cand_oh, pick_oh, bag_set;
  logic [CW-1:0]    wr_idx;

  // A full bag is cleared the cycle it completes, so some piece is always free.
  always_comb begin
    lowest_free = 3'd0;
    for (int k = 6; k >= 0; k--) begin
      if (!bag_q[k]) lowest_free = 3'(k + 1);
    end
  end

  always_comb begin
    cand_oh = 7'd0;
    if (bus.rand_val != 3'd0) cand_oh = 7'd1 << (bus.rand_val - 3'd1);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    slot_d  = slot_q;
    bag_d   = bag_q;
    tries_d = tries_q;
    valid_d = 1'b0;
    id_d    = id_q;
    dealt_d = dealt_q;
    accept  = 1'b0;
    pick    = 3'd0;
    pick_oh = 7'd0;
    bag_set = bag_q;
    wr_idx  = '0;

    // valid_q blocks a second pop while the game FSM still holds its request.
    pop = bus.piece_req && (count_q != '0) && !valid_q;

    if (state_q == S_FILL) begin
      if ((cand_oh != 7'd0) && ((bag_q & cand_oh) == 7'd0)) begin
        accept = 1'b1;
        pick   = bus.rand_val;
      end else if (tries_q == C_LAST_TRY) begin
        accept = 1'b1;
        pick   = lowest_free;
      end else begin
        tries_d = tries_q + TW'(1);
      end
    end

    if (pop) begin
      valid_d = 1'b1;
      id_d    = slot_q[0];
      dealt_d = dealt_q + CNT_W'(1);
      for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i + 1];
      slot_d[DEPTH-1] = 3'd0;
    end

    // The write index is taken after the shift when a pop happens alongside.
    wr_idx = count_q - CW'(pop);
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) slot_d[i] = pick;
      end
      pick_oh = 7'd1 << (pick - 3'd1);
      bag_set = bag_q | pick_oh;
      bag_d   = (bag_set == 7'h7F) ? 7'd0 : bag_set;
      tries_d = '0;
    end

    count_d = count_q - CW'(pop) + CW'(accept);
    state_d = (count_d == C_DEPTH) ? S_FULL : S_FILL;

    if (bus.new_game) begin
      state_d = S_FILL;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) slot_d[i] = 3'd0;
      bag_d   = 7'd0;
      tries_d = '0;
      valid_d = 1'b0;
      id_d    = 3'd0;
      dealt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= 3'd0;
      bag_q   <= 7'd0;
      tries_q <= '0;
      valid_q <= 1'b0;
      id_q    <= 3'd0;
      dealt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      bag_q   <= bag_d;
      tries_q <= tries_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      dealt_q <= dealt_d;
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_preview
      assign bus.preview[3*g +: 3] = slot_q[g];
    end
  endgenerate

  assign bus.piece_valid  = valid_q;
  assign bus.piece_id     = id_q;
  assign bus.queue_full   = (state_q == S_FULL);
  assign bus.bag_mask     = bag_q;
  assign bus.pieces_dealt = dealt_q;
endmodule
`default_nettype wire

// File: tb/tb_piece_queue_sched.sv
`default_nettype none
// ============================================================================
// tb_piece_queue_sched : directed bench for piece_queue_sched with a queue-level
//                        reference model compared every cycle.
// Revision 1.0
// ============================================================================
module tb_piece_queue_sched;
  localparam int DEPTH     = 3;
  localparam int MAX_TRIES = 4;
  localparam int CNT_W     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  piece_queue_sched_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  piece_queue_sched #(
    .DEPTH    (DEPTH),
    .MAX_TRIES(MAX_TRIES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int pulses   = 0;

  // Reference model: the queue as a list of pieces, the bag as a used-set.
  int m_q[$];
  bit m_used[1:7];
  int m_tries = 0;
  bit m_valid = 1'b0;
  int m_id    = 0;
  int m_dealt = 0;

  task automatic m_clear();
    m_q.delete();
    for (int k = 1; k <= 7; k++) m_used[k] = 1'b0;
    m_tries = 0;
    m_valid = 1'b0;
    m_id    = 0;
    m_dealt = 0;
  endtask

  task automatic m_step();
    int piece;
    int rv;
    bit do_pop;
    bit all_used;
    piece = 0;
    rv    = int'(bus.rand_val);
    if (bus.new_game) begin
      m_clear();
      return;
    end
    do_pop = bus.piece_req && (m_q.size() > 0) && !m_valid;
    if (m_q.size() < DEPTH) begin
      if (rv != 0 && !m_used[rv]) begin
        piece = rv;
      end else if (m_tries == MAX_TRIES - 1) begin
        for (int k = 7; k >= 1; k--) if (!m_used[k]) piece = k;
      end else begin
        m_tries++;
      end
    end
    m_valid = do_pop;
    if (do_pop) begin
      m_id    = m_q.pop_front();
      m_dealt = (m_dealt + 1) % (1 << CNT_W);
    end
    if (piece != 0) begin
      m_q.push_back(piece);
      m_used[piece] = 1'b1;
      m_tries = 0;
      all_used = 1'b1;
      for (int k = 1; k <= 7; k++) if (!m_used[k]) all_used = 1'b0;
      if (all_used) for (int k = 1; k <= 7; k++) m_used[k] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_clear();
    else        m_step();
  end

  function automatic logic [3*DEPTH-1:0] m_preview();
    logic [3*DEPTH-1:0] p;
    p = '0;
    for (int i = 0; i < DEPTH; i++) if (i < m_q.size()) p[3*i +: 3] = 3'(m_q[i]);
    return p;
  endfunction

  function automatic logic [6:0] m_bag();
    logic [6:0] b;
    b = 7'd0;
    for (int k = 1; k <= 7; k++) b[k-1] = m_used[k];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model piece_valid",  32'(bus.piece_valid),  32'(m_valid));
      check("model piece_id",     32'(bus.piece_id),     32'(m_id));
      check("model preview",      32'(bus.preview),      32'(m_preview()));
      check("model queue_full",   32'(bus.queue_full),   32'(m_q.size() == DEPTH));
      check("model bag_mask",     32'(bus.bag_mask),     32'(m_bag()));
      check("model pieces_dealt", 32'(bus.pieces_dealt), 32'(m_dealt));
    end
  end

  task automatic step(input logic [2:0] rv, input logic req, input logic ng);
    bus.rand_val  = rv;
    bus.piece_req = req;
    bus.new_game  = ng;
    @(negedge clk);
    if (bus.piece_valid === 1'b1) pulses++;
  endtask

  initial begin
    bus.new_game  = 1'b0;
    bus.rand_val  = 3'd0;
    bus.piece_req = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset preview",    32'(bus.preview),      32'd0);
    check("reset valid",      32'(bus.piece_valid),  32'd0);
    check("reset dealt",      32'(bus.pieces_dealt), 32'd0);
    #1 rst_n = 1'b1;

    // Reset in the middle of filling.
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    check("fill two preview", 32'(bus.preview),  32'h011);
    check("fill two bag",     32'(bus.bag_mask), 32'h03);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midfill reset preview", 32'(bus.preview),    32'd0);
    check("midfill reset bag",     32'(bus.bag_mask),   32'd0);
    check("midfill reset full",    32'(bus.queue_full), 32'd0);
    check("midfill reset id",      32'(bus.piece_id),   32'd0);
    #1 rst_n = 1'b1;

    // 3,3,5,1: duplicate rejected, queue fills as {1,5,3}.
    step(3'd3, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    check("dup reject preview", 32'(bus.preview),  32'h003);
    check("dup reject bag",     32'(bus.bag_mask), 32'h04);
    step(3'd5, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    check("bag fill preview", 32'(bus.preview),    32'h06B);
    check("bag fill full",    32'(bus.queue_full), 32'd1);
    check("bag fill mask",    32'(bus.bag_mask),   32'h15);

    // Forced picks after MAX_TRIES rejections.
    step(3'd0, 1'b0, 1'b1);
    check("new_game preview", 32'(bus.preview), 32'd0);
    step(3'd2, 1'b0, 1'b0);
    repeat (3) step(3'd2, 1'b0, 1'b0);
    check("three rejects no force", 32'(bus.preview), 32'h002);
    step(3'd2, 1'b0, 1'b0);
    check("forced piece 1", 32'(bus.preview), 32'h00A);
    repeat (4) step(3'd2, 1'b0, 1'b0);
    check("forced piece 3 preview", 32'(bus.preview),    32'h0CA);
    check("forced piece 3 bag",     32'(bus.bag_mask),   32'h07);
    check("forced full",            32'(bus.queue_full), 32'd1);

    // 7..1 with continuous popping; rand 0 where the queue is full.
    step(3'd0, 1'b0, 1'b1);
    step(3'd7, 1'b1, 1'b0);
    step(3'd6, 1'b1, 1'b0);
    step(3'd5, 1'b1, 1'b0);
    step(3'd4, 1'b1, 1'b0);
    step(3'd3, 1'b1, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    step(3'd2, 1'b1, 1'b0);
    check("bag before wrap", 32'(bus.bag_mask), 32'h7E);
    step(3'd0, 1'b1, 1'b0);
    check("stream pulse",    32'(bus.piece_valid), 32'd1);
    check("stream piece id", 32'(bus.piece_id),    32'd4);
    step(3'd1, 1'b1, 1'b0);
    check("bag wrap",      32'(bus.bag_mask),     32'h00);
    check("wrap preview",  32'(bus.preview),      32'h053);
    check("stream dealt",  32'(bus.pieces_dealt), 32'd4);

    // Held request on a full queue: one pulse, then refill.
    step(3'd0, 1'b0, 1'b0);
    pulses = 0;
    step(3'd0, 1'b1, 1'b0);
    check("held req pulse", 32'(bus.piece_valid), 32'd1);
    check("held req id",    32'(bus.piece_id),    32'd3);
    check("held req full",  32'(bus.queue_full),  32'd0);
    step(3'd0, 1'b1, 1'b0);
    check("held req no double", 32'(bus.piece_valid), 32'd0);
    step(3'd5, 1'b0, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    check("held req one pulse", 32'(pulses),           32'd1);
    check("refill preview",     32'(bus.preview),      32'h14A);
    check("refill full",        32'(bus.queue_full),   32'd1);
    check("held req id kept",   32'(bus.piece_id),     32'd3);

    // new_game beats a simultaneous pop and accept.
    step(3'd0, 1'b1, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    step(3'd6, 1'b1, 1'b1);
    check("ng valid",   32'(bus.piece_valid),  32'd0);
    check("ng preview", 32'(bus.preview),      32'd0);
    check("ng dealt",   32'(bus.pieces_dealt), 32'd0);
    check("ng bag",     32'(bus.bag_mask),     32'd0);
    step(3'd0, 1'b0, 1'b0);
    check("ng still idle", 32'(bus.piece_valid), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
